lcd_bus_arbiter: RTL
====================

# lcd_bus_arbiter

Shared-bus controller for the character LCD. It runs the power-up initialisation sequence itself, then grants the LCD bus to one of two requesters using round-robin arbitration. Example requesters are a keypad/character writer and a cursor/status writer. Each granted request becomes one timed LCD transaction with an explicit enable strobe and a completion ack. It sits between the application FSMs and the LCD pins, so no requester drives LCD_RS/LCD_RW/LCD_DATA directly.

## Interface
- INIT_DELAY, 70: power-up wait in clk cycles before the first init command.
- CMD_CYCLES, 30: length of every normal transaction in cycles; legal range 4..255.
- CLEAR_CYCLES, 100: length of the clear-display init step; legal range 4..255.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request; held high until the matching ack.
- req_rs  in  2  per-requester RS value (0 = command, 1 = data); stable while req is high.
- req_data0  in  8  requester 0 byte; stable while req[0] is high.
- req_data1  in  8  requester 1 byte; stable while req[1] is high.
- ack  out  2  one-cycle completion pulse per requester.
- grant  out  2  one-hot, high for the whole transaction of the served requester.
- init_done  out  1  high once the init sequence completes; stays high until reset.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  always 0 (write-only).
- LCD_DATA  out  8  LCD data bus.

## Operation
- States: S_DELAY, S_INIT, S_IDLE, S_XFER. An 8-bit cycle counter cnt and a 2-bit init step index.
- **S_DELAY:** counts 0..INIT_DELAY-1, then moves to S_INIT with step 0.
- **S_INIT:** issues four commands, each as a transaction with RS=0:
  - 0x38, 0x0F and 0x06, each lasting CMD_CYCLES;
  - then 0x01, lasting CLEAR_CYCLES;
  - then sets init_done=1 and moves to S_IDLE.
- **S_IDLE:** arbitrates among the asserted req bits.
  - One requester asserted: it wins.
  - Both asserted: the winner is the one not served last (round-robin pointer). The pointer resets to "1 served last", so requester 0 wins the first tie.
  - The winner's rs and data are latched into LCD_RS/LCD_DATA, its grant bit is set, the pointer is updated, and the state moves to S_XFER.
- **S_XFER:** lasts CMD_CYCLES cycles, cnt = 0..CMD_CYCLES-1.
  - LCD_RS/LCD_DATA are held at the latched values for the whole transaction.
  - On cnt = CMD_CYCLES-1, ack[winner]=1 and the state returns to S_IDLE.
  - grant drops on the same edge that leaves S_XFER.
- **Requests during S_DELAY/S_INIT:** stay pending and are not acked; they are served in S_IDLE after init_done rises.
- **req dropped mid-transaction:** the transaction still completes and ack still pulses. The requester must tolerate the stray ack.
- **Idle bus values:** LCD_E=0, LCD_RS=0, LCD_DATA holds its last value, LCD_RW=0.
- **Reset (asynchronous, any time, including mid-transaction or mid-init):**
  - state=S_DELAY, cnt=0, step=0, pointer=1;
  - ack=0, grant=0, init_done=0;
  - LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00.
  - The init sequence restarts from the beginning.

## Timing
- All outputs are registered; no combinational path from req to the LCD pins.
- Request-to-bus latency: req rising at edge k is seen in S_IDLE. LCD_RS/LCD_DATA/grant are valid from edge k+1, with cnt=0 in the first S_XFER cycle.
- LCD_E within each transaction of length N (init or S_XFER):
  - 0 at cnt=0 (setup);
  - 1 for cnt = 1..N-3;
  - 0 for cnt = N-2 and N-1 (hold).
- ack is high exactly in the cycle where cnt=N-1. The requester deasserts req on the edge where it samples ack=1. S_IDLE therefore always lasts at least one cycle between transactions, so the same request is never served twice.
- Back-to-back throughput: one transaction per CMD_CYCLES+1 cycles.
- Init completes at cycle INIT_DELAY + 3·CMD_CYCLES + CLEAR_CYCLES after reset release, plus one S_IDLE transition cycle. Defaults: 70+90+100 = 260.

## Test plan
- **Reset and init:** release rst with req=0 and default parameters.
  - LCD_DATA sequence 0x38, 0x0F, 0x06, 0x01, each with RS=0.
  - init_done rises 260 cycles after release.
  - No ack during this period.
- **Single request:** req[0]=1, rs=1, data0=0x31 after init.
  - grant=01 for 30 cycles, LCD_DATA=0x31, RS=1.
  - LCD_E high for 27 cycles.
  - ack[0] pulses once at cycle 30.
- **Tie arbitration:** both req high continuously, with data0=0x41 and data1=0x42.
  - Serve order 0, 1, 0, 1.
  - One S_IDLE cycle between transactions.
  - Each ack aligned with its own grant.
- **Early request:** req[1]=1 asserted during S_DELAY.
  - No ack before init_done.
  - Served first transaction after init.
- **Withdrawn request:** req[0] dropped at cnt=10 of its transaction.
  - Transaction runs the full 30 cycles.
  - ack[0] still pulses.
  - Next arbitration ignores requester 0.
- **Mid-transaction reset:** rst pulsed low at cnt=15 of S_XFER.
  - All outputs return to reset values immediately (asynchronous).
  - After release, the full init sequence replays.

Source files
------------

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_arbiter_if
// Description : Requester-side handshake bundle for the LCD bus arbiter.
//               Each of the two requesters presents a request bit, an RS
//               value and a data byte. The arbiter answers with a one-hot
//               grant for the whole transaction and a one-cycle ack.
//   req        [1:0]  per-requester request, held until the matching ack
//   req_rs     [1:0]  per-requester register select (0 cmd, 1 data)
//   req_data0  [7:0]  requester 0 byte
//   req_data1  [7:0]  requester 1 byte
//   ack        [1:0]  one-cycle completion pulse per requester
//   grant      [1:0]  one-hot, high for the whole served transaction
// Revision    : 1.0  initial release
// ============================================================================
interface lcd_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] req_rs;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] ack;
  logic [1:0] grant;

  // Requester side drives requests and consumes grant/ack.
  modport master (
    output req, req_rs, req_data0, req_data1,
    input  ack, grant
  );

  // Arbiter side consumes requests and drives grant/ack.
  modport slave (
    input  req, req_rs, req_data0, req_data1,
    output ack, grant
  );
endinterface
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_arbiter
// Description : Character-LCD bus owner. After reset it waits INIT_DELAY
//               cycles, issues the four-command init sequence (0x38, 0x0F,
//               0x06, 0x01), then serves two requesters round-robin. Every
//               command is a timed transaction with a setup cycle, an enable
//               pulse and two hold cycles. All outputs are registered.
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   bus        --   requester handshake (slave modport)
//   init_done  out  high once the init sequence has completed
//   LCD_E      out  enable strobe
//   LCD_RS     out  register select
//   LCD_RW     out  read/write select, tied to write
//   LCD_DATA   out  data bus
// Revision    : 1.0  initial release
// ============================================================================
module lcd_bus_arbiter #(
  parameter int INIT_DELAY   = 70,
  parameter int CMD_CYCLES   = 30,
  parameter int CLEAR_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  lcd_bus_arbiter_if.slave  bus,
  output logic              init_done,
  output logic              LCD_E,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic [7:0]        LCD_DATA
);

  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_INIT  = 2'd1,
    S_IDLE  = 2'd2,
    S_XFER  = 2'd3
  } state_t;

  // Terminal counts (length - 1) in the counter's own width.
  localparam logic [7:0] DELAY_LAST = 8'(INIT_DELAY - 1);
  localparam logic [7:0] CMD_LAST   = 8'(CMD_CYCLES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_cmd = 8'h0F;   // display on, cursor on, blink on
      2'd2:    init_cmd = 8'h06;   // entry mode: increment, no shift
      default: init_cmd = 8'h01;   // clear display
    endcase
  endfunction

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] step, step_nx;
  logic       last, last_nx;       // index of the requester served last
  logic       winner, winner_nx;   // index of the requester being served
  logic       init_done_nx;
  logic [1:0] ack_nx, grant_nx;
  logic       e_nx, rs_nx;
  logic [7:0] data_nx;
  logic       pick;
  logic [7:0] init_last;
  logic [7:0] len_last_nx;
  logic       active_nx;

  assign LCD_RW = 1'b0;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was
  // served last; otherwise requester 0 wins.
  assign pick      = bus.req[1] & (~bus.req[0] | ~last);
  assign init_last = (step == 2'd3) ? CLEAR_LAST : CMD_LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_DELAY;
      cnt       <= '0;
      step      <= '0;
      last      <= 1'b1;
      winner    <= 1'b0;
      init_done <= 1'b0;
      bus.ack   <= '0;
      bus.grant <= '0;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      step      <= step_nx;
      last      <= last_nx;
      winner    <= winner_nx;
      init_done <= init_done_nx;
      bus.ack   <= ack_nx;
      bus.grant <= grant_nx;
      LCD_E     <= e_nx;
      LCD_RS    <= rs_nx;
      LCD_DATA  <= data_nx;
    end
  end

  // Next-state logic plus the next values of every registered output. The
  // outputs are derived from the *next* state/counter so that, once
  // registered, they line up with the cnt value of the cycle they appear in.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    step_nx      = step;
    last_nx      = last;
    winner_nx    = winner;
    init_done_nx = init_done;
    ack_nx       = 2'b00;
    grant_nx     = 2'b00;
    e_nx         = 1'b0;
    rs_nx        = 1'b0;
    data_nx      = LCD_DATA;
    len_last_nx  = CMD_LAST;
    active_nx    = 1'b0;

    case (state)
      S_DELAY: begin
        if (cnt == DELAY_LAST) begin
          state_nx = S_INIT;
          cnt_nx   = '0;
          step_nx  = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_INIT: begin
        if (cnt == init_last) begin
          cnt_nx = '0;
          if (step == 2'd3) begin
            state_nx     = S_IDLE;
            init_done_nx = 1'b1;
          end else begin
            step_nx = step + 2'd1;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          state_nx  = S_XFER;
          cnt_nx    = '0;
          winner_nx = pick;
          last_nx   = pick;
        end
      end
      S_XFER: begin
        if (cnt == CMD_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: begin
        state_nx = S_DELAY;
        cnt_nx   = '0;
      end
    endcase

    active_nx = (state_nx == S_INIT) || (state_nx == S_XFER);
    if ((state_nx == S_INIT) && (step_nx == 2'd3)) begin
      len_last_nx = CLEAR_LAST;
    end

    // Enable: low on the setup cycle and the two hold cycles at the end.
    e_nx = active_nx && (cnt_nx != 8'd0) && (cnt_nx < (len_last_nx - 8'd1));

    if (state_nx == S_XFER) begin
      grant_nx = winner_nx ? 2'b10 : 2'b01;
      if (cnt_nx == CMD_LAST) begin
        ack_nx[winner_nx] = 1'b1;
      end
    end

    // Bus values are captured from the requester once, on entry, so a
    // requester that withdraws or changes its inputs mid-transaction cannot
    // disturb the LCD pins.
    if ((state == S_IDLE) && (state_nx == S_XFER)) begin
      rs_nx   = bus.req_rs[pick];
      data_nx = pick ? bus.req_data1 : bus.req_data0;
    end else if (state_nx == S_XFER) begin
      rs_nx   = LCD_RS;
      data_nx = LCD_DATA;
    end else if (state_nx == S_INIT) begin
      rs_nx   = 1'b0;
      data_nx = init_cmd(step_nx);
    end
  end

endmodule
`default_nettype wire
